controle_servo_pwm: RTL and testbench
=====================================

# controle_servo_pwm

Servo PWM generator that sits directly downstream of the up/down position counter in the Cyclone Cruiser sweep path. Each period it latches the counter's position, converts it to a pulse width, and drives one servo pulse. It also emits a one-cycle end-of-period strobe, which the team wires back as the counter's `conta` input. Result: the sweep advances exactly one position per servo frame, and a pulse is never truncated.

## Interface
- `PERIODO`, default 1000000: clock cycles per PWM frame (20 ms at 50 MHz).
- `LARGURA_MIN`, default 50000: pulse width in cycles for position 0 (1 ms).
- `PASSO`, default 1000: extra pulse cycles per position unit.
- `M_POS`, default 50: number of valid positions (0..M_POS-1).
- `N_POS`, default 6: width of the position bus.
- `clock  in  1`: single clock; every flop is on its rising edge.
- `zera_s  in  1`: reset, synchronous, active-high.
- `habilita  in  1`: run request; sampled only at frame boundaries and while stopped.
- `posicao  in  N_POS`: target position from the up/down counter (`Q`).
- `pwm  out  1`: servo pulse.
- `fim_periodo  out  1`: one-cycle strobe on the last cycle of each active frame.
- `posicao_atual  out  N_POS`: position applied to the current frame.
- `erro_posicao  out  1`: high for any frame whose latched `posicao` was ≥ `M_POS`.

## Operation
- FSM states: `PARADO`, `ATIVO`.
- **`PARADO`**
  - `cnt` = 0; `pwm` = 0; `fim_periodo` = 0.
  - When `habilita`=1: latch the position, compute `largura`, go to `ATIVO`.
- **`ATIVO`**
  - `cnt` runs 0..`PERIODO`-1.
  - At `cnt`=`PERIODO`-1: `fim_periodo`=1.
  - At that same boundary: if `habilita`=1, latch the new position, set `cnt` to 0 and stay in `ATIVO`; otherwise go to `PARADO`.
- **Latch rule**
  - `p` = `posicao` < `M_POS` ? `posicao` : `M_POS`-1.
  - `erro_posicao` is set to (`posicao` ≥ `M_POS`).
  - `posicao_atual` ← `p`.
  - `largura` ← `LARGURA_MIN` + `p`*`PASSO`.
- **Arithmetic**
  - `cnt` and `largura` are $clog2(`PERIODO`) bits wide.
  - The product is computed at that width, with no truncation.
  - Legal parameters satisfy `LARGURA_MIN` + (`M_POS`-1)*`PASSO` < `PERIODO`, so every frame has a low phase.
- **Pulse**
  - `pwm` = (`estado`==`ATIVO`) && (`cnt` < `largura`).
  - `pwm` is driven from registered state only, so it is glitch-free.
- **Mid-frame changes**
  - A change on `posicao` mid-frame has no effect until the next boundary.
  - `habilita` falling mid-frame lets the frame complete; it is never truncated.
- **Reset values**
  - `estado` = `PARADO`, `cnt` = 0, `largura` = `LARGURA_MIN`.
  - `pwm` = 0, `fim_periodo` = 0, `posicao_atual` = 0, `erro_posicao` = 0.
  - `zera_s` wins over every other input, including mid-pulse.

## Timing
- **Start:** with `habilita` seen high in `PARADO` at edge k, the first frame's cycle `cnt`=0 is cycle k+1, and `pwm` is high from k+1.
- **Pulse length:** `pwm` is high for exactly `largura` consecutive cycles, then low for `PERIODO`-`largura` cycles.
- **Strobe:** `fim_periodo` is high for exactly one cycle per frame, the cycle where `cnt`=`PERIODO`-1, and is never asserted in `PARADO`.
- **Sampling point:** the position is sampled at the same edge that ends the frame. An upstream counter stepping on `fim_periodo` updates `Q` after that edge, so the new `Q` is applied one frame later. This one-frame lag is intentional.
- **Reset:** `zera_s` seen at edge k forces `pwm`=0 from cycle k+1.

## Configuration
- Macro: `CONTROLE_SERVO_RAMPA_EN`.
- **Defined:** at each latch, `posicao_atual` moves at most one step toward the clamped `p` (+1, -1 or hold). `largura` follows `posicao_atual`, which limits servo slew to one position per frame.
- **Undefined:** `posicao_atual` jumps straight to `p`.
- `erro_posicao` and clamping behave the same in both builds.

## Structure
- Shared package/header holds:
  - default values of `PERIODO`, `LARGURA_MIN`, `PASSO`, `M_POS`, `N_POS`;
  - state encoding `PARADO`=1'b0, `ATIVO`=1'b1.
- One sub-module is natural: `contador_periodo`.
  - Modulo-`PERIODO` counter with `zera` and `conta` inputs.
  - Outputs: `cnt` and a terminal-count flag.
- Clamp, latch, ramp, compare logic and FSM live in `controle_servo_pwm`.

## Test plan
Bench parameters: `PERIODO`=100, `LARGURA_MIN`=10, `PASSO`=1, `M_POS`=50, `N_POS`=6.
- **Reset/idle:** `zera_s` pulse, `habilita`=1, `posicao`=0 → `pwm` high 10 cycles, low 90; `fim_periodo` pulses every 100 cycles; after reset, all outputs are 0 until `habilita` is seen.
- **Full scale:** `posicao`=49 → `pwm` high 59 cycles per frame; `posicao_atual`=49; `erro_posicao`=0.
- **Mid-frame change:** `posicao` 5→20 at `cnt`=3 → current frame pulse 15 cycles, next frame 30 cycles.
- **Clamp:** `posicao`=60 → `pwm` high 59 cycles; `posicao_atual`=49; `erro_posicao`=1; back to `posicao`=7 → `erro_posicao`=0 after the next boundary.
- **Stop and reset:**
  - `habilita`→0 at `cnt`=30 → frame finishes with its final `fim_periodo`, then `pwm` stays 0 and no further strobes.
  - `zera_s` at `cnt`=5 of a pulse → `pwm`=0 the next cycle.
- **Ramp (`CONTROLE_SERVO_RAMPA_EN` defined):** `posicao` 0→3 → `posicao_atual` 1, 2, 3 on three successive frames; pulse widths 11, 12, 13.

Source files
------------

// File: rtl/controle_servo_pwm_pkg.sv
// Shared defaults and FSM encoding for the servo PWM generator.
// Optional slew limiting is enabled by defining CONTROLE_SERVO_RAMPA_EN.
package controle_servo_pwm_pkg;

    localparam int PERIODO_PADRAO     = 1000000;
    localparam int LARGURA_MIN_PADRAO = 50000;
    localparam int PASSO_PADRAO       = 1000;
    localparam int M_POS_PADRAO       = 50;
    localparam int N_POS_PADRAO       = 6;

    typedef enum logic {
        PARADO = 1'b0,
        ATIVO  = 1'b1
    } estado_t;

endpackage

// File: rtl/controle_servo_pwm_contador_periodo.sv
// Modulo-PERIODO frame counter: zera clears, conta advances, wraps after the terminal count.
module contador_periodo #(
    parameter int PERIODO = 1000000,
    parameter int W       = $clog2(PERIODO)
) (
    input  logic         clock,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] cnt,
    output logic         fim
);

    localparam logic [W-1:0] ULTIMO = W'(PERIODO - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (conta) begin
            cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign fim = (cnt_q == ULTIMO);

endmodule

// File: rtl/controle_servo_pwm.sv
// Servo PWM generator: latches the position at each frame boundary and drives one pulse per frame.
// Define CONTROLE_SERVO_RAMPA_EN to limit posicao_atual to one step per frame.
module controle_servo_pwm
    import controle_servo_pwm_pkg::*;
#(
    parameter int PERIODO     = PERIODO_PADRAO,
    parameter int LARGURA_MIN = LARGURA_MIN_PADRAO,
    parameter int PASSO       = PASSO_PADRAO,
    parameter int M_POS       = M_POS_PADRAO,
    parameter int N_POS       = N_POS_PADRAO
) (
    input  logic             clock,
    input  logic             zera_s,
    input  logic             habilita,
    input  logic [N_POS-1:0] posicao,
    output logic             pwm,
    output logic             fim_periodo,
    output logic [N_POS-1:0] posicao_atual,
    output logic             erro_posicao
);

    localparam int W = $clog2(PERIODO);
    localparam logic [W-1:0]     LARGURA_MIN_W = W'(LARGURA_MIN);
    localparam logic [W-1:0]     PASSO_W       = W'(PASSO);
    localparam logic [N_POS:0]   M_POS_W       = (N_POS + 1)'(M_POS);
    localparam logic [N_POS-1:0] POS_MAX       = N_POS'(M_POS - 1);

    estado_t          estado_q, estado_d;
    logic [W-1:0]     cnt;
    logic             tc;
    logic             latch;
    logic [W-1:0]     largura_q, largura_d;
    logic [N_POS-1:0] pos_q, pos_d, p_clamp;
    logic             erro_q, erro_d;

    contador_periodo #(
        .PERIODO (PERIODO),
        .W       (W)
    ) u_contador (
        .clock (clock),
        .zera  (zera_s || (estado_q == PARADO)),
        .conta (estado_q == ATIVO),
        .cnt   (cnt),
        .fim   (tc)
    );

    always_ff @(posedge clock) begin
        if (zera_s) begin
            estado_q <= PARADO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        latch    = 1'b0;
        case (estado_q)
            PARADO: begin
                if (habilita) begin
                    latch    = 1'b1;
                    estado_d = ATIVO;
                end
            end
            ATIVO: begin
                if (tc) begin
                    if (habilita) begin
                        latch = 1'b1;
                    end else begin
                        estado_d = PARADO;
                    end
                end
            end
            default: estado_d = PARADO;
        endcase
    end

    always_comb begin
        pwm         = (estado_q == ATIVO) && (cnt < largura_q);
        fim_periodo = (estado_q == ATIVO) && tc;
    end

    // Out-of-range positions are clamped to the last valid one and flagged for that frame.
    always_comb begin
        p_clamp   = ({1'b0, posicao} < M_POS_W) ? posicao : POS_MAX;
        pos_d     = pos_q;
        erro_d    = erro_q;
        largura_d = largura_q;
        if (latch) begin
            erro_d = ({1'b0, posicao} >= M_POS_W);
`ifdef CONTROLE_SERVO_RAMPA_EN
            if (pos_q < p_clamp) begin
                pos_d = pos_q + N_POS'(1);
            end else if (pos_q > p_clamp) begin
                pos_d = pos_q - N_POS'(1);
            end
`else
            pos_d = p_clamp;
`endif
            largura_d = LARGURA_MIN_W + W'(pos_d) * PASSO_W;
        end
    end

    always_ff @(posedge clock) begin
        if (zera_s) begin
            pos_q     <= '0;
            erro_q    <= 1'b0;
            largura_q <= LARGURA_MIN_W;
        end else begin
            pos_q     <= pos_d;
            erro_q    <= erro_d;
            largura_q <= largura_d;
        end
    end

    assign posicao_atual = pos_q;
    assign erro_posicao  = erro_q;

endmodule

// File: tb/tb_controle_servo_pwm.sv
// Directed self-checking bench for controle_servo_pwm (PERIODO=100, LARGURA_MIN=10, PASSO=1, M_POS=50).
// The ramp scenario expectations follow CONTROLE_SERVO_RAMPA_EN.
module tb_controle_servo_pwm;

    logic       clock;
    logic       zera_s;
    logic       habilita;
    logic [5:0] posicao;
    logic       pwm;
    logic       fim_periodo;
    logic [5:0] posicao_atual;
    logic       erro_posicao;

    int compared;
    int mismatched;

    controle_servo_pwm #(
        .PERIODO     (100),
        .LARGURA_MIN (10),
        .PASSO       (1),
        .M_POS       (50),
        .N_POS       (6)
    ) dut (
        .clock         (clock),
        .zera_s        (zera_s),
        .habilita      (habilita),
        .posicao       (posicao),
        .pwm           (pwm),
        .fim_periodo   (fim_periodo),
        .posicao_atual (posicao_atual),
        .erro_posicao  (erro_posicao)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts from the current negedge through the cycle that shows fim_periodo, then steps to the next frame start.
    task automatic measure_frame(output int high, output int len, output bit seen);
        high = 0;
        len  = 0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            len++;
            if (pwm) high++;
            if (fim_periodo) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
    endtask

    task automatic test_reset;
        int h, l;
        bit s;
        zera_s   = 1'b1;
        habilita = 1'b0;
        posicao  = 6'd0;
        repeat (2) @(negedge clock);
        zera_s = 1'b0;
        compared++;
        if ({pwm, fim_periodo, posicao_atual, erro_posicao} !== 9'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got pwm=%b fim=%b pos=%0d erro=%b, want all 0",
                     pwm, fim_periodo, posicao_atual, erro_posicao);
        end
        h = 0;
        repeat (5) begin
            @(negedge clock);
            if (pwm || fim_periodo) h++;
        end
        compared++;
        if (h !== 0) begin
            mismatched++;
            $display("[TB] FAIL idle_quiet: got %0d active cycles, want 0", h);
        end
        habilita = 1'b1;
        @(negedge clock);
        compared++;
        if (pwm !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL start_pwm: got %b, want 1", pwm);
        end
        for (int f = 0; f < 2; f++) begin
            measure_frame(h, l, s);
            compared++;
            if (!s || h !== 10 || l !== 100) begin
                mismatched++;
                $display("[TB] FAIL pos0_frame%0d: got high=%0d len=%0d strobe=%b, want 10/100/1", f, h, l, s);
            end
        end
    endtask

    task automatic test_ramp;
        int h, l;
        bit s;
        int exp_pos[3];
`ifdef CONTROLE_SERVO_RAMPA_EN
        exp_pos = '{1, 2, 3};
`else
        exp_pos = '{3, 3, 3};
`endif
        posicao = 6'd3;
        measure_frame(h, l, s);
        compared++;
        if (h !== 10) begin
            mismatched++;
            $display("[TB] FAIL ramp_old_frame: got high=%0d, want 10", h);
        end
        for (int f = 0; f < 3; f++) begin
            compared++;
            if (posicao_atual !== 6'(exp_pos[f])) begin
                mismatched++;
                $display("[TB] FAIL ramp_pos%0d: got %0d, want %0d", f, posicao_atual, exp_pos[f]);
            end
            measure_frame(h, l, s);
            compared++;
            if (!s || h !== 10 + exp_pos[f] || l !== 100) begin
                mismatched++;
                $display("[TB] FAIL ramp_width%0d: got high=%0d len=%0d, want %0d/100", f, h, l, 10 + exp_pos[f]);
            end
        end
    endtask

    task automatic test_full_scale;
        int h, l;
        bit s;
        posicao = 6'd49;
        measure_frame(h, l, s);
        compared++;
        if (posicao_atual !== 6'd49 || erro_posicao !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_scale_latch: got pos=%0d erro=%b, want 49/0", posicao_atual, erro_posicao);
        end
        measure_frame(h, l, s);
        compared++;
        if (!s || h !== 59 || l !== 100) begin
            mismatched++;
            $display("[TB] FAIL full_scale_width: got high=%0d len=%0d, want 59/100", h, l);
        end
    endtask

    task automatic test_mid_frame;
        int h, l, pre;
        bit s;
        posicao = 6'd5;
        measure_frame(h, l, s);
        pre = 0;
        repeat (3) begin
            if (pwm) pre++;
            @(negedge clock);
        end
        posicao = 6'd20;
        measure_frame(h, l, s);
        compared++;
        if (!s || h + pre !== 15 || l + 3 !== 100) begin
            mismatched++;
            $display("[TB] FAIL mid_frame_current: got high=%0d len=%0d, want 15/100", h + pre, l + 3);
        end
        measure_frame(h, l, s);
        compared++;
        if (!s || h !== 30) begin
            mismatched++;
            $display("[TB] FAIL mid_frame_next: got high=%0d, want 30", h);
        end
    endtask

    task automatic test_clamp;
        int h, l;
        bit s;
        posicao = 6'd60;
        measure_frame(h, l, s);
        compared++;
        if (posicao_atual !== 6'd49 || erro_posicao !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL clamp_latch: got pos=%0d erro=%b, want 49/1", posicao_atual, erro_posicao);
        end
        posicao = 6'd7;
        measure_frame(h, l, s);
        compared++;
        if (!s || h !== 59) begin
            mismatched++;
            $display("[TB] FAIL clamp_width: got high=%0d, want 59", h);
        end
        compared++;
        if (erro_posicao !== 1'b0 || posicao_atual !== 6'd7) begin
            mismatched++;
            $display("[TB] FAIL clamp_recover: got pos=%0d erro=%b, want 7/0", posicao_atual, erro_posicao);
        end
    endtask

    task automatic test_stop_and_reset;
        int h, l, pre, act;
        bit s;
        pre = 0;
        repeat (30) begin
            if (pwm) pre++;
            @(negedge clock);
        end
        habilita = 1'b0;
        measure_frame(h, l, s);
        compared++;
        if (!s || h + pre !== 17 || l + 30 !== 100) begin
            mismatched++;
            $display("[TB] FAIL stop_last_frame: got high=%0d len=%0d strobe=%b, want 17/100/1", h + pre, l + 30, s);
        end
        act = 0;
        repeat (150) begin
            if (pwm || fim_periodo) act++;
            @(negedge clock);
        end
        compared++;
        if (act !== 0) begin
            mismatched++;
            $display("[TB] FAIL stopped_quiet: got %0d active cycles, want 0", act);
        end
        habilita = 1'b1;
        @(negedge clock);
        repeat (5) @(negedge clock);
        compared++;
        if (pwm !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL restart_pwm: got %b, want 1", pwm);
        end
        zera_s = 1'b1;
        @(negedge clock);
        compared++;
        if (pwm !== 1'b0 || posicao_atual !== 6'd0 || erro_posicao !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_pulse: got pwm=%b pos=%0d erro=%b, want 0/0/0",
                     pwm, posicao_atual, erro_posicao);
        end
        zera_s = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        zera_s     = 1'b1;
        habilita   = 1'b0;
        posicao    = 6'd0;
        test_reset();
        test_ramp();
`ifndef CONTROLE_SERVO_RAMPA_EN
        test_full_scale();
        test_mid_frame();
        test_clamp();
        test_stop_and_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
